serial_pattern_tx: RTL and testbench

Bit-serial pattern transmitter that feeds a serial pattern detector; the detector recognises sequence 1101011, and this block generates it. It latches a PAT_W-bit pattern on start and shifts it out MSB-first, one bit per clock. It can repeat the frame a programmable number of times with optional idle gaps between frames. It is used as the stimulus/source end of the serial detection link and as a standalone frame generator.

---
 rtl/serial_pattern_tx_if.sv | 31 +++
 rtl/serial_pattern_tx.sv | 160 ++++++++++++++++
 tb/tb_serial_pattern_tx.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/serial_pattern_tx_if.sv
// serial_pattern_tx_if
// Bundles the control inputs and serial outputs of serial_pattern_tx.
//   master : pattern source controller (drives start/config, observes stream)
//   slave  : the transmitter itself
// Signals:
//   start, use_default, pat_in[PAT_W], repeat_cnt[CNT_W], abort  (master -> slave)
//   dataout, busy, frame_start, done                              (slave -> master)
interface serial_pattern_tx_if #(
    parameter int PAT_W = 7,
    parameter int CNT_W = 4
);
    logic             start;
    logic             use_default;
    logic [PAT_W-1:0] pat_in;
    logic [CNT_W-1:0] repeat_cnt;
    logic             abort;
    logic             dataout;
    logic             busy;
    logic             frame_start;
    logic             done;

    modport master (
        output start, use_default, pat_in, repeat_cnt, abort,
        input  dataout, busy, frame_start, done
    );

    modport slave (
        input  start, use_default, pat_in, repeat_cnt, abort,
        output dataout, busy, frame_start, done
    );
endinterface

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
// Bit-serial pattern transmitter. Latches a PAT_W-bit pattern on an accepted
// start and shifts it out MSB-first, repeating the frame max(repeat_cnt,1)
// times with GAP idle bit-times between frames.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : serial_pattern_tx_if.slave (start/use_default/pat_in/repeat_cnt/
//            abort in; dataout/busy/frame_start/done out, all registered)
// Optional feature macro SERIAL_PATTERN_TX_PARITY_EN: appends an even-parity
// bit after each frame's LSB, making frames PAT_W+1 bits long.
//
// state | meaning
// IDLE  | waiting for start, outputs low
// SHIFT | shifting frame bits out (and parity bit when enabled)
// GAP   | idle zeros between consecutive frames, busy held high
// DONE  | one-cycle done pulse, then back to IDLE
module serial_pattern_tx #(
    parameter int               PAT_W   = 7,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(7'b1101011),
    parameter int               CNT_W   = 4,
    parameter int               GAP     = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_pattern_tx_if.slave  bus
);

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    localparam int FRAME_LEN = PAT_W + 1;
`else
    localparam int FRAME_LEN = PAT_W;
`endif
    localparam int BW = 6;
    localparam logic [BW-1:0] LAST_IDX = BW'(FRAME_LEN - 1);
    localparam logic [7:0]    GAP_M1   = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [PAT_W-1:0] pat_q;       // latched pattern, reloaded for each frame
    logic [PAT_W-1:0] shreg_q;     // bits still to be sent, MSB next
    logic [BW-1:0]    bit_cnt_q;   // bits remaining in frame after current one
    logic [CNT_W-1:0] frames_q;    // frames remaining including current one
    logic [7:0]       gap_cnt_q;
    logic             dataout_q;
    logic             busy_q;
    logic             frame_start_q;
    logic             done_q;

    logic [PAT_W-1:0] start_pat_d;
    logic [CNT_W-1:0] start_frames_d;
    logic             next_bit_d;

    assign start_pat_d    = bus.use_default ? PATTERN : bus.pat_in;
    assign start_frames_d = (bus.repeat_cnt == '0) ? CNT_W'(1) : bus.repeat_cnt;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    logic parity_d;
    assign parity_d   = ^pat_q;
    // Last remaining slot of the frame carries the parity bit.
    assign next_bit_d = (bit_cnt_q == BW'(1)) ? parity_d : shreg_q[PAT_W-1];
`else
    assign next_bit_d = shreg_q[PAT_W-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pat_q         <= '0;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            frames_q      <= '0;
            gap_cnt_q     <= '0;
            dataout_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
        end else if (bus.abort) begin
            state_q       <= S_IDLE;
            dataout_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    dataout_q <= 1'b0;
                    busy_q    <= 1'b0;
                    if (bus.start) begin
                        pat_q         <= start_pat_d;
                        shreg_q       <= start_pat_d << 1;
                        frames_q      <= start_frames_d;
                        bit_cnt_q     <= LAST_IDX;
                        dataout_q     <= start_pat_d[PAT_W-1];
                        busy_q        <= 1'b1;
                        frame_start_q <= 1'b1;
                        state_q       <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bit_cnt_q != '0) begin
                        dataout_q <= next_bit_d;
                        shreg_q   <= shreg_q << 1;
                        bit_cnt_q <= bit_cnt_q - BW'(1);
                    end else if (frames_q > CNT_W'(1)) begin
                        frames_q <= frames_q - CNT_W'(1);
                        if (GAP > 0) begin
                            dataout_q <= 1'b0;
                            gap_cnt_q <= GAP_M1;
                            state_q   <= S_GAP;
                        end else begin
                            // Back-to-back: next MSB on the very next cycle.
                            shreg_q       <= pat_q << 1;
                            bit_cnt_q     <= LAST_IDX;
                            dataout_q     <= pat_q[PAT_W-1];
                            frame_start_q <= 1'b1;
                        end
                    end else begin
                        frames_q  <= '0;
                        dataout_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q != 8'd0) begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end else begin
                        shreg_q       <= pat_q << 1;
                        bit_cnt_q     <= LAST_IDX;
                        dataout_q     <= pat_q[PAT_W-1];
                        frame_start_q <= 1'b1;
                        state_q       <= S_SHIFT;
                    end
                end
                S_DONE: begin
                    dataout_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.dataout     = dataout_q;
    assign bus.busy        = busy_q;
    assign bus.frame_start = frame_start_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx. Instance A has GAP=0, instance B GAP=2.
// Each check compares the packed output vector {dataout,busy,frame_start,done}.
module tb_serial_pattern_tx;
    localparam int PAT_W = 7;
    localparam int CNT_W = 4;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    localparam int FL = PAT_W + 1;
`else
    localparam int FL = PAT_W;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [6:0] det_hist = '0;
    int   det_cnt = 0;

    always #5 clk = ~clk;

    serial_pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) ifa ();
    serial_pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) ifb ();

    serial_pattern_tx #(.PAT_W(PAT_W), .PATTERN(7'b1101011), .CNT_W(CNT_W), .GAP(0))
        u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    serial_pattern_tx #(.PAT_W(PAT_W), .PATTERN(7'b1101011), .CNT_W(CNT_W), .GAP(2))
        u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    logic [3:0] obs_a, obs_b;
    assign obs_a = {ifa.dataout, ifa.busy, ifa.frame_start, ifa.done};
    assign obs_b = {ifb.dataout, ifb.busy, ifb.frame_start, ifb.done};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input logic st, input logic ud,
                         input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] rep);
        if (s) begin
            ifb.start = st; ifb.use_default = ud; ifb.pat_in = pat; ifb.repeat_cnt = rep;
        end else begin
            ifa.start = st; ifa.use_default = ud; ifa.pat_in = pat; ifa.repeat_cnt = rep;
        end
    endtask

    task automatic do_start(input bit s, input logic ud,
                            input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] rep);
        drive(s, 1'b1, ud, pat, rep);
        tick();
        drive(s, 1'b0, 1'b0, 7'h00, 4'h0);
    endtask

    // Walks the expected stream cycle by cycle; optionally pokes a stray start
    // mid-stream, or aborts at a given cycle index (0 = first bit).
    task automatic expect_stream(input bit s, input logic [PAT_W-1:0] pat, input int frames,
                                 input int gap, input int poke_at, input int abort_at,
                                 input string tag);
        int n = 0;
        logic b;
        logic [3:0] exp;
        for (int f = 0; f < frames; f++) begin
            for (int i = 0; i < FL; i++) begin
                b = (i < PAT_W) ? pat[PAT_W-1-i] : ^pat;
                exp = {b, 1'b1, (i == 0), 1'b0};
                check(tag, s ? obs_b : obs_a, exp);
                det_hist = {det_hist[5:0], (s ? obs_b[3] : obs_a[3])};
                if (det_hist == 7'b1101011) det_cnt++;
                if (n == abort_at) begin
                    if (s) ifb.abort = 1'b1; else ifa.abort = 1'b1;
                    tick();
                    ifa.abort = 1'b0; ifb.abort = 1'b0;
                    check({tag, "_abort"}, s ? obs_b : obs_a, 4'b0000);
                    return;
                end
                if (n == poke_at) drive(s, 1'b1, 1'b0, 7'h00, 4'hF);
                tick();
                if (n == poke_at) drive(s, 1'b0, 1'b0, 7'h7F, 4'h2);
                n++;
            end
            if (f < frames - 1) begin
                for (int g = 0; g < gap; g++) begin
                    check({tag, "_gap"}, s ? obs_b : obs_a, 4'b0100);
                    tick();
                end
            end
        end
        check({tag, "_done"}, s ? obs_b : obs_a, 4'b0001);
        tick();
        check({tag, "_idle"}, s ? obs_b : obs_a, 4'b0000);
    endtask

    initial begin
        ifa.abort = 1'b0; ifb.abort = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 7'h00, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 7'h00, 4'h0);
        #1 rst_n = 1'b0;
        #2;
        check("reset_a", obs_a, 4'b0000);
        check("reset_b", obs_b, 4'b0000);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_a", obs_a, 4'b0000);

        // 1: default pattern, single frame, detector fires once
        det_hist = '0; det_cnt = 0;
        do_start(1'b0, 1'b1, 7'h00, 4'd1);
        expect_stream(1'b0, 7'b1101011, 1, 0, -1, -1, "s1");
        check("s1_detect", det_cnt, 1);

        // 2: user pattern, three back-to-back frames
        do_start(1'b0, 1'b0, 7'b1010101, 4'd3);
        expect_stream(1'b0, 7'b1010101, 3, 0, -1, -1, "s2");

        // 3: GAP=2 instance, two frames
        do_start(1'b1, 1'b1, 7'h00, 4'd2);
        expect_stream(1'b1, 7'b1101011, 2, 2, -1, -1, "s3");

        // 4: repeat_cnt=0 sends exactly one frame
        do_start(1'b0, 1'b1, 7'h00, 4'd0);
        expect_stream(1'b0, 7'b1101011, 1, 0, -1, -1, "s4");

        // 5: abort on 4th bit, no done afterwards, then clean restart
        do_start(1'b0, 1'b1, 7'h00, 4'd1);
        expect_stream(1'b0, 7'b1101011, 1, 0, -1, 3, "s5");
        for (int k = 0; k < 3; k++) begin
            tick();
            check("s5_no_done", obs_a, 4'b0000);
        end
        do_start(1'b0, 1'b1, 7'h00, 4'd1);
        expect_stream(1'b0, 7'b1101011, 1, 0, -1, -1, "s5_restart");

        // 5b: start pulsed mid-frame with different config is ignored
        do_start(1'b0, 1'b1, 7'h00, 4'd1);
        expect_stream(1'b0, 7'b1101011, 1, 0, 2, -1, "s5_poke");

        // 6: async reset between clock edges mid-frame
        do_start(1'b0, 1'b1, 7'h00, 4'd2);
        tick();
        tick();
        check("s6_mid_busy", {31'd0, obs_a[2]}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("s6_async_reset", obs_a, 4'b0000);
        tick();
        rst_n = 1'b1;
        tick();
        check("s6_after_reset", obs_a, 4'b0000);
        do_start(1'b0, 1'b1, 7'h00, 4'd1);
        expect_stream(1'b0, 7'b1101011, 1, 0, -1, -1, "s6_restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
